// File: rtl/register_file_sb.sv
// ID-stage integer register file with NREAD combinational read ports, one WB write port,
// a per-register busy scoreboard for RAW detection and a post-reset clear sequence.
module register_file_sb #(
    parameter  int XLEN  = 32,
    parameter  int NREG  = 32,
    parameter  int NREAD = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    output logic [NREAD-1:0]      rbusy,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_rd,
    output logic                  ready
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREG - 1);

    state_t            state;
    logic [AW:0]       clr_idx;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [XLEN-1:0]   mem [NREG];
    logic              wr_ok;
    logic              iss_ok;

    assign wr_ok  = we && (wa != '0);
    assign iss_ok = iss_en && (iss_rd != '0);

    // Issue is applied after retirement so a new producer of the same register stays outstanding.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[wa] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    busy <= busy_nxt;
                end
                default: begin
                    state <= CLEAR;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // The array has no reset of its own; the clear sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[clr_idx[AW-1:0]] <= '0;
            end else if (wr_ok) begin
                mem[wa] <= wd;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0] addr;
        logic          byp;

        assign addr = ra[i*AW +: AW];
        assign byp  = we && (wa == addr);

        // Reads are forced to zero until the clear finishes so uninitialised storage never leaks.
        assign rd[i*XLEN +: XLEN] = (!ready || addr == '0) ? '0 :
                                    (byp ? wd : mem[addr]);
        assign rbusy[i] = ready && busy[addr] && !(byp && (wa != '0));
    end

endmodule

// File: tb/tb_register_file_sb.sv
// Directed scoreboard bench for register_file_sb: expectations are queued with the stimulus
// and popped against the DUT outputs once they have settled.
module tb_register_file_sb;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst;
    logic [NREAD*AW-1:0]   ra;
    logic [NREAD*XLEN-1:0] rd;
    logic [NREAD-1:0]      rbusy;
    logic                  we;
    logic [AW-1:0]         wa;
    logic [XLEN-1:0]       wd;
    logic                  iss_en;
    logic [AW-1:0]         iss_rd;
    logic                  ready;

    typedef enum int {K_RD0, K_RD1, K_BUSY0, K_BUSY1, K_READY} kind_t;

    typedef struct {
        string           tag;
        kind_t           kind;
        logic [XLEN-1:0] val;
    } exp_t;

    exp_t sbQueue[$];
    int   checkCount = 0;
    int   errorCount = 0;

    register_file_sb #(.XLEN(XLEN), .NREG(NREG), .NREAD(NREAD)) dut (
        .clk    (clk),
        .rst    (rst),
        .ra     (ra),
        .rd     (rd),
        .rbusy  (rbusy),
        .we     (we),
        .wa     (wa),
        .wd     (wd),
        .iss_en (iss_en),
        .iss_rd (iss_rd),
        .ready  (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic weV, input logic [AW-1:0] waV, input logic [XLEN-1:0] wdV,
                                 input logic issV, input logic [AW-1:0] issRdV);
        we     = weV;
        wa     = waV;
        wd     = wdV;
        iss_en = issV;
        iss_rd = issRdV;
        #1;
    endtask

    task automatic setReads(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    task automatic expectOut(input string tag, input kind_t kind, input logic [XLEN-1:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sbQueue.push_back(e);
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t            e;
        logic [XLEN-1:0] obs;
        while (sbQueue.size() > 0) begin
            e = sbQueue.pop_front();
            case (e.kind)
                K_RD0:   obs = rd[0 +: XLEN];
                K_RD1:   obs = rd[XLEN +: XLEN];
                K_BUSY0: obs = {{(XLEN-1){1'b0}}, rbusy[0]};
                K_BUSY1: obs = {{(XLEN-1){1'b0}}, rbusy[1]};
                default: obs = {{(XLEN-1){1'b0}}, ready};
            endcase
            checkCount++;
            assert (obs === e.val) else begin
                errorCount++;
                $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    // Counts edges until ready rises, giving up well beyond the expected clear length.
    task automatic countClear(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        ra  = '0;
        applyStimulus(1'b0, '0, '0, 1'b0, '0);

        // T1: reset held two cycles, then a full clear with writes and issues that must be ignored
        tick();
        tick();
        setReads(5, 6);
        expectOut("t1_ready_in_reset", K_READY, 0);
        expectOut("t1_rd0_in_reset", K_RD0, 0);
        expectOut("t1_rbusy0_in_reset", K_BUSY0, 0);
        checkOutput();
        rst = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd6);
        expectOut("t1_rd0_clear_bypass_blocked", K_RD0, 0);
        expectOut("t1_rd1_clear", K_RD1, 0);
        checkOutput();
        countClear(n);
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        checkValue("t1_clear_edges", n, NREG);
        expectOut("t1_ready_after_clear", K_READY, 1);
        expectOut("t1_rbusy1_issue_ignored", K_BUSY1, 0);
        checkOutput();
        for (int i = 0; i < NREG; i++) begin
            setReads(i[AW-1:0], 5'(NREG - 1 - i));
            expectOut($sformatf("t1_rd0_zero_r%0d", i), K_RD0, 0);
            expectOut($sformatf("t1_rd1_zero_r%0d", NREG - 1 - i), K_RD1, 0);
            checkOutput();
        end

        // T2: write bypass only while we is high
        setReads(5, 5);
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0);
        expectOut("t2_bypass_rd0", K_RD0, 32'hDEAD_BEEF);
        expectOut("t2_bypass_rd1", K_RD1, 32'hDEAD_BEEF);
        checkOutput();
        tick();
        applyStimulus(1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, '0);
        expectOut("t2_mem_rd0", K_RD0, 32'hDEAD_BEEF);
        checkOutput();
        applyStimulus(1'b0, 5'd5, 32'h1, 1'b0, '0);
        expectOut("t2_no_bypass_when_we0", K_RD0, 32'hDEAD_BEEF);
        checkOutput();
        tick();
        expectOut("t2_no_write_when_we0", K_RD0, 32'hDEAD_BEEF);
        checkOutput();

        // T3: register 0 stays zero and is never busy
        setReads(0, 0);
        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0);
        expectOut("t3_r0_same_cycle", K_RD0, 0);
        checkOutput();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd0);
        expectOut("t3_r0_next_cycle", K_RD0, 0);
        checkOutput();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        expectOut("t3_r0_never_busy", K_BUSY0, 0);
        checkOutput();

        // T4: issue marks busy, the retiring write hides and then clears it
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd7);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        setReads(7, 8);
        expectOut("t4_busy_after_issue", K_BUSY0, 1);
        expectOut("t4_other_not_busy", K_BUSY1, 0);
        checkOutput();
        applyStimulus(1'b1, 5'd7, 32'd9, 1'b0, '0);
        expectOut("t4_bypass_hides_busy", K_BUSY0, 0);
        expectOut("t4_bypass_data", K_RD0, 9);
        checkOutput();
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        expectOut("t4_busy_cleared", K_BUSY0, 0);
        expectOut("t4_mem_written", K_RD0, 9);
        checkOutput();

        // T5: issue and retire of the same register at one edge leaves it busy
        applyStimulus(1'b0, '0, '0, 1'b1, 5'd3);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        setReads(3, 0);
        expectOut("t5_busy_set", K_BUSY0, 1);
        checkOutput();
        applyStimulus(1'b1, 5'd3, 32'h55, 1'b1, 5'd3);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        expectOut("t5_set_wins", K_BUSY0, 1);
        expectOut("t5_mem_written", K_RD0, 32'h55);
        checkOutput();

        // T6: reset during RUN, then reset again in the middle of the clear
        applyStimulus(1'b1, 5'd4, 32'd8, 1'b1, 5'd4);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, '0);
        setReads(4, 3);
        expectOut("t6_busy4_before", K_BUSY0, 1);
        expectOut("t6_mem4_before", K_RD0, 8);
        checkOutput();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        expectOut("t6_ready_low", K_READY, 0);
        expectOut("t6_rbusy0_low", K_BUSY0, 0);
        expectOut("t6_rd0_low", K_RD0, 0);
        checkOutput();
        countClear(n);
        checkValue("t6_clear_edges", n, NREG);
        expectOut("t6_mem4_cleared", K_RD0, 0);
        expectOut("t6_busy4_cleared", K_BUSY0, 0);
        expectOut("t6_busy3_cleared", K_BUSY1, 0);
        checkOutput();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        expectOut("t6_mid_clear_ready", K_READY, 0);
        checkOutput();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        countClear(n);
        checkValue("t6_restart_edges", n, NREG);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
